opcode_decoder: RTL and testbench

Registered instruction-opcode decoder for the MBC datapath. It converts the 3-bit binary OPCODE field of the current instruction into an 8-bit one-hot DECODED_SIGNAL bus, one line per instruction class. The control unit uses this bus to select datapath operations. The block also reports decode validity, opcode changes, and the last captured opcode for control and debug logic.

---
 rtl/opcode_decoder.sv | 71 +++++++
 tb/tb_opcode_decoder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/opcode_decoder.sv
// Registered binary-to-one-hot opcode decoder with capture validity,
// change strobe and a copy of the last captured opcode.
module opcode_decoder #(
  parameter int unsigned OPCODE_WIDTH = 3
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          EN,
  input  logic [OPCODE_WIDTH-1:0]       OPCODE,
  output logic [(2**OPCODE_WIDTH)-1:0]  DECODED_SIGNAL,
  output logic                          VALID,
  output logic                          CHANGED,
  output logic [OPCODE_WIDTH-1:0]       LAST_OPCODE
);

  localparam int unsigned DECODED_WIDTH = 2 ** OPCODE_WIDTH;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [DECODED_WIDTH-1:0]   decoded_q, decoded_d;
  logic [OPCODE_WIDTH-1:0]    last_q, last_d;
  logic                       changed_q, changed_d;
  logic [DECODED_WIDTH-1:0]   onehot;

  // Per-line compare; an unknown opcode leaves every line low, which also clears VALID
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < DECODED_WIDTH; i++) begin
      if (OPCODE == OPCODE_WIDTH'(i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    decoded_d = decoded_q;
    last_d    = last_q;
    changed_d = 1'b0;
    if (EN) begin
      last_d    = OPCODE;
      decoded_d = onehot;
      state_d   = (|onehot) ? LOADED : EMPTY;
      changed_d = (state_q == EMPTY) || (OPCODE != last_q);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= EMPTY;
      decoded_q <= '0;
      last_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      decoded_q <= decoded_d;
      last_q    <= last_d;
      changed_q <= changed_d;
    end
  end

  assign DECODED_SIGNAL = decoded_q;
  assign VALID          = (state_q == LOADED);
  assign CHANGED        = changed_q;
  assign LAST_OPCODE    = last_q;

endmodule

// File: tb/tb_opcode_decoder.sv
// Self-checking bench for opcode_decoder: directed scenarios plus random
// EN/OPCODE traffic compared against a behavioural capture model.
module tb_opcode_decoder;

  localparam int unsigned OW = 3;
  localparam int unsigned DW = 2 ** OW;

  logic          CLK;
  logic          RST;
  logic          EN;
  logic [OW-1:0] OPCODE;
  logic [DW-1:0] DECODED_SIGNAL;
  logic          VALID;
  logic          CHANGED;
  logic [OW-1:0] LAST_OPCODE;

  int n_checks;
  int n_errors;

  // Reference model state: what the decoder should remember
  bit      m_valid;
  int      m_last;
  bit      m_changed;

  opcode_decoder #(.OPCODE_WIDTH(OW)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .EN             (EN),
    .OPCODE         (OPCODE),
    .DECODED_SIGNAL (DECODED_SIGNAL),
    .VALID          (VALID),
    .CHANGED        (CHANGED),
    .LAST_OPCODE    (LAST_OPCODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_last    = 0;
    m_changed = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    int exp_dec;
    exp_dec = m_valid ? (2 ** m_last) : 0;
    check({tag, ".decoded"}, 32'(DECODED_SIGNAL), 32'(exp_dec));
    check({tag, ".valid"},   32'(VALID),          32'(m_valid));
    check({tag, ".changed"}, 32'(CHANGED),        32'(m_changed));
    check({tag, ".last"},    32'(LAST_OPCODE),    32'(m_last));
  endtask

  // Drive one cycle of stimulus, advance the model, and compare after the edge
  task automatic step(input bit en, input int op, input string tag);
    EN     = en;
    OPCODE = OW'(op);
    @(posedge CLK);
    if (en) begin
      m_changed = !m_valid || (op != m_last);
      m_last    = op;
      m_valid   = 1'b1;
    end else begin
      m_changed = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();

    // Reset asserted before any edge with EN high: outputs clear without a clock
    RST = 1'b1; EN = 1'b1; OPCODE = OW'(5);
    #2;
    check_outputs("reset_async");
    repeat (2) @(posedge CLK);
    #1;
    check_outputs("reset_hold");
    RST = 1'b0;

    for (int i = 0; i < 8; i++) step(1'b1, i, "sweep");

    for (int i = 0; i < 3; i++) step(1'b1, 5, "repeat5");

    step(1'b1, 3, "en_cap3");
    for (int i = 0; i < 4; i++) step(1'b0, 6, "en_hold");
    step(1'b1, 6, "en_resume");

    // Mid-cycle reset after capturing 7, then recapture the same opcode
    step(1'b1, 7, "rst_cap7");
    RST = 1'b1;
    #2;
    model_reset();
    check_outputs("rst_mid_async");
    @(posedge CLK);
    #1;
    check_outputs("rst_mid_hold");
    RST = 1'b0;
    step(1'b1, 7, "rst_recap7");

    for (int c = 0; c < 1000; c++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, DW - 1)), "random");
      check("random.popcount", 32'($countones(DECODED_SIGNAL)), 32'(m_valid));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
